// File: rtl/revaluate_rho_engine_if.sv
// Start/done handshake and shared state-memory port between the controller side and the rho engine.
// The engine is the slave; the controller plus the state memory form the master side.
interface revaluate_rho_engine_if #(
  parameter int LANE_W = 64,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [LANE_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [LANE_W-1:0] mem_wr_data;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output mem_rd_data,
    input  mem_addr,
    input  mem_rd_en,
    input  mem_wr_en,
    input  mem_wr_data,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  mem_rd_data,
    output mem_addr,
    output mem_rd_en,
    output mem_wr_en,
    output mem_wr_data,
    output busy,
    output done
  );
endinterface

// File: rtl/revaluate_rho_engine.sv
// In-place rho step over the 24 non-origin lanes of a 5x5 state held in external memory.
// Latency: start taken at the end of cycle S, done high in cycle S+73; no backpressure, memory must honour every strobe.
module revaluate_rho_engine #(
  parameter int LANE_W = 64,
  parameter int ADDR_W = 5
) (
  input logic                   clk,
  input logic                   rst,
  revaluate_rho_engine_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [4:0]        t;
  logic [2:0]        x;
  logic [2:0]        y;
  logic [5:0]        off;
  logic [LANE_W-1:0] lane;

  logic              last_step;
  logic [4:0]        traj_sum;
  logic [2:0]        y_nxt;
  logic [4:0]        addr5;
  logic [ADDR_W-1:0] lane_addr;
  logic [31:0]       rot_amt;
  logic [LANE_W-1:0] lane_rot;

  assign last_step = (t == 5'd23);

  // (x,y) -> (y, (2x+3y) mod 5) using shifts and adds; the sum never exceeds 20
  always_comb begin
    traj_sum = {1'b0, x, 1'b0} + {1'b0, y, 1'b0} + {2'b00, y};
    if (traj_sum >= 5'd20) begin
      y_nxt = 3'(traj_sum - 5'd20);
    end else if (traj_sum >= 5'd15) begin
      y_nxt = 3'(traj_sum - 5'd15);
    end else if (traj_sum >= 5'd10) begin
      y_nxt = 3'(traj_sum - 5'd10);
    end else if (traj_sum >= 5'd5) begin
      y_nxt = 3'(traj_sum - 5'd5);
    end else begin
      y_nxt = traj_sum[2:0];
    end
  end

  // lane address 5*y + x
  assign addr5     = {y, 2'b00} + {2'b00, y} + {2'b00, x};
  assign lane_addr = ADDR_W'(addr5);

  // barrel rotate; a zero amount shifts the right term out entirely, leaving lane unchanged
  always_comb begin
    rot_amt  = 32'(off) % 32'(LANE_W);
    lane_rot = (lane << rot_amt) | (lane >> (32'(LANE_W) - rot_amt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.mem_addr    = '0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        bus.busy      = 1'b1;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = lane_addr;
        state_nxt     = WAIT;
      end
      WAIT: begin
        bus.busy  = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        bus.busy        = 1'b1;
        bus.mem_wr_en   = 1'b1;
        bus.mem_addr    = lane_addr;
        bus.mem_wr_data = lane_rot;
        state_nxt       = last_step ? DONE : READ;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // walk counters are reloaded every IDLE cycle so each run starts at (1,0) with off=1
  always_ff @(posedge clk) begin
    if (rst) begin
      t    <= 5'd0;
      x    <= 3'd1;
      y    <= 3'd0;
      off  <= 6'd1;
      lane <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          t   <= 5'd0;
          x   <= 3'd1;
          y   <= 3'd0;
          off <= 6'd1;
        end
        WAIT: begin
          lane <= bus.mem_rd_data;
        end
        WRITE: begin
          if (!last_step) begin
            t   <= t + 5'd1;
            off <= off + {1'b0, t} + 6'd2;
            x   <= y;
            y   <= y_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_rd_en && bus.mem_wr_en));

  a_no_origin: assert property (@(posedge clk) disable iff (rst)
    (bus.mem_rd_en || bus.mem_wr_en) |-> (bus.mem_addr != '0));

endmodule

// File: tb/tb_revaluate_rho_engine.sv
// Scoreboarded bench for revaluate_rho_engine: a lane-level rho model predicts every
// memory access and the busy/done timeline; a negedge monitor compares what the DUT does.
module tb_revaluate_rho_engine;
  localparam int LANE_W = 64;
  localparam int ADDR_W = 5;

  typedef logic [LANE_W-1:0] lane_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    lane_t             dat;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  revaluate_rho_engine_if #(.LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus ();

  revaluate_rho_engine #(.LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // state memory: one-cycle read latency, write at the edge
  lane_t mem      [25];
  lane_t init_mem [25];
  logic  load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      mem <= init_mem;
    end else if (bus.mem_wr_en && bus.mem_addr < 5'd25) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
    end
    bus.mem_rd_data <= (bus.mem_rd_en && bus.mem_addr < 5'd25) ? mem[bus.mem_addr] : '0;
  end

  // reference model
  int traj [24] = '{1, 10, 7, 11, 17, 18, 3, 5, 16, 8, 21, 24, 4, 15, 23, 19, 13, 12, 2, 20, 14, 22, 9, 6};

  function automatic int off_of(int t);
    return ((t + 1) * (t + 2) / 2) % 64;
  endfunction

  function automatic lane_t rotl(lane_t v, int n);
    lane_t r = v;
    for (int i = 0; i < n % LANE_W; i++) r = {r[LANE_W-2:0], r[LANE_W-1]};
    return r;
  endfunction

  lane_t model_mem [25];
  lane_t pre_mem   [25];
  wr_t                exp_wr [$];
  logic [ADDR_W-1:0]  exp_rd [$];
  int   run_start  = -1000;
  bit   run_valid  = 1'b0;
  int   model_free = 0;
  bit   mon_en     = 1'b0;
  int   errors     = 0;
  int   checks     = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic commit(int k);
    for (int t = 0; t < k; t++) model_mem[traj[t]] = rotl(model_mem[traj[t]], off_of(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive start for the current cycle; the engine takes it only when the model says it is idle
  task automatic set_start(bit v);
    bus.start = v;
    if (v && !rst && cyc >= model_free) begin
      run_valid  = 1'b1;
      run_start  = cyc;
      model_free = cyc + 74;
      pre_mem    = model_mem;
      for (int t = 0; t < 24; t++) begin
        exp_rd.push_back(ADDR_W'(traj[t]));
        exp_wr.push_back(wr_t'{addr: ADDR_W'(traj[t]), dat: rotl(model_mem[traj[t]], off_of(t))});
      end
      commit(24);
    end
  endtask

  task automatic load_mem();
    load = 1'b1;
    tick();
    load = 1'b0;
    model_mem = init_mem;
  endtask

  task automatic check_mem(string tag);
    for (int a = 0; a < 25; a++) check($sformatf("%s mem[%0d]", tag, a), mem[a], model_mem[a]);
  endtask

  task automatic check_drained(string tag);
    check($sformatf("%s wr queue drained", tag), 64'(exp_wr.size()), 64'd0);
    check($sformatf("%s rd queue drained", tag), 64'(exp_rd.size()), 64'd0);
  endtask

  // monitor
  logic mon_busy, mon_done;
  wr_t  mon_w;
  logic [ADDR_W-1:0] mon_a;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_busy = run_valid && cyc >= run_start + 1 && cyc <= run_start + 73;
      mon_done = run_valid && cyc == run_start + 73;
      check("busy", 64'(bus.busy), 64'(mon_busy));
      check("done", 64'(bus.done), 64'(mon_done));
      check("strobe exclusive", 64'(bus.mem_rd_en && bus.mem_wr_en), 64'd0);
      if (!bus.mem_rd_en && !bus.mem_wr_en) check("idle addr", 64'(bus.mem_addr), 64'd0);
      if (bus.mem_rd_en) begin
        if (exp_rd.size() == 0) begin
          check("unexpected read", 64'd1, 64'd0);
        end else begin
          mon_a = exp_rd.pop_front();
          check("rd addr", 64'(bus.mem_addr), 64'(mon_a));
        end
      end
      if (bus.mem_wr_en) begin
        if (exp_wr.size() == 0) begin
          check("unexpected write", 64'd1, 64'd0);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wr addr", 64'(bus.mem_addr), 64'(mon_w.addr));
          check("wr data", bus.mem_wr_data, mon_w.dat);
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    for (int a = 0; a < 25; a++) init_mem[a] = '0;

    // reset values
    while (cyc < 3) tick();
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("reset wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("reset addr", 64'(bus.mem_addr), 64'd0);
    check("reset wr_data", bus.mem_wr_data, 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // golden image, lane 1 carries an MSB/LSB pattern
    for (int a = 0; a < 25; a++) init_mem[a] = 64'(a) * 64'h0101_0101_0101_0101;
    init_mem[1] = 64'h8000_0000_0000_0001;
    load_mem();

    // run A at cycle 10, ignored pulses at 40 (busy) and 83 (DONE), run B at 84
    while (cyc < 10) tick();
    set_start(1'b1);
    while (cyc < 84) begin
      tick();
      set_start(cyc == 40 || cyc == 83 || cyc == 84);
    end
    check("run A lane 1", mem[1], 64'h0000_0000_0000_0003);
    check("run A lane 6", mem[6], rotl(64'h0606_0606_0606_0606, 44));
    check("run A lane 0", mem[0], 64'd0);
    tick();
    set_start(1'b0);
    while (cyc < model_free + 1) tick();
    check_drained("b2b");
    check("b2b lane 0", mem[0], init_mem[0]);
    for (int t = 0; t < 24; t++)
      check($sformatf("b2b lane %0d", traj[t]), mem[traj[t]],
            rotl(init_mem[traj[t]], (2 * off_of(t)) % 64));

    // abort during step t=5 (its WAIT cycle)
    for (int a = 0; a < 25; a++) init_mem[a] = {$urandom, $urandom};
    load_mem();
    set_start(1'b1);
    repeat (17) begin
      tick();
      set_start(1'b0);
    end
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    run_valid  = 1'b0;
    model_free = cyc;
    check("abort rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("abort wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("abort addr", 64'(bus.mem_addr), 64'd0);
    check("abort wr left", 64'(exp_wr.size()), 64'd19);
    check("abort rd left", 64'(exp_rd.size()), 64'd18);
    exp_wr.delete();
    exp_rd.delete();
    model_mem = pre_mem;
    commit(5);
    repeat (3) tick();
    check_mem("abort");

    // randomized runs with spurious start pulses while busy
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 25; a++) init_mem[a] = {$urandom, $urandom};
      load_mem();
      repeat ($urandom_range(0, 3)) tick();
      set_start(1'b1);
      while (cyc < model_free - 1) begin
        tick();
        set_start($urandom_range(0, 7) == 0);
      end
      tick();
      set_start(1'b0);
      repeat (2) tick();
      check_drained($sformatf("rand%0d", r));
      check_mem($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
